mmio_input_event_ctrl: RTL

//   Memory-mapped input/output controller between the processor data bus and the board buttons, switches and LEDs.

---
 rtl/mmio_input_event_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mmio_input_event_ctrl.sv
// Memory-mapped button/switch/LED controller: synchronises and debounces buttons into
// sticky press events read one at a time, exposes synchronised switches and an LED register.
module mmio_input_event_ctrl #(
    parameter int NUM_BTN         = 4,
    parameter int NUM_SW          = 16,
    parameter int LED_W           = 16,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ADDR_W          = 32,
    parameter logic [ADDR_W-1:0] BTN_ADDR = ADDR_W'(4096),
    parameter logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(4097),
    parameter logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(4)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_SW-1:0]  sw_raw,
    input  logic [ADDR_W-1:0]  bus_addr,
    input  logic [31:0]        bus_wdata,
    input  logic               bus_wren,
    input  logic               bus_rden,
    output logic               io_hit,
    output logic [31:0]        io_rdata,
    output logic [LED_W-1:0]   led,
    output logic [NUM_BTN-1:0] btn_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] btn_meta, btn_sync;
    logic [NUM_SW-1:0]  sw_meta, sw_sync;
    logic [CNT_W-1:0]   cnt      [NUM_BTN];
    logic [CNT_W-1:0]   cnt_next [NUM_BTN];
    logic [NUM_BTN-1:0] lvl, lvl_next, rise;
    logic [NUM_BTN-1:0] pend, pend_next, clr_onehot;
    logic [31:0]        btn_code;
    logic               btn_sel, sw_sel, btn_read, led_write;
    logic               unused_wdata;

    assign unused_wdata = ^bus_wdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            sw_meta  <= sw_raw;
            sw_sync  <= sw_meta;
        end
    end

    // A level is accepted only after the synchronised input has differed from it
    // for DEBOUNCE_CYCLES consecutive cycles; an accepted 0->1 change is a press.
    always_comb begin
        lvl_next = lvl;
        rise     = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_next[i] = '0;
            if (btn_sync[i] != lvl[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    lvl_next[i] = btn_sync[i];
                    rise[i]     = btn_sync[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign btn_sel   = (bus_addr == BTN_ADDR);
    assign sw_sel    = (bus_addr == SW_ADDR);
    assign io_hit    = btn_sel | sw_sel;
    assign btn_read  = bus_rden & btn_sel;
    assign led_write = bus_wren & (bus_addr == LED_ADDR);

    // Lowest pending index wins; the code is index+1 so that 0 means "nothing pending".
    always_comb begin
        btn_code   = '0;
        clr_onehot = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pend[i]) begin
                btn_code      = 32'(i + 1);
                clr_onehot    = '0;
                clr_onehot[i] = 1'b1;
            end
        end
    end

    // A press landing in the same cycle as its own clear keeps the event pending.
    assign pend_next = (pend & ~(btn_read ? clr_onehot : '0)) | rise;

    always_comb begin
        io_rdata = '0;
        if (btn_sel) begin
            io_rdata = btn_code;
        end else if (sw_sel) begin
            io_rdata = 32'(sw_sync);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
            lvl  <= '0;
            pend <= '0;
            led  <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= cnt_next[i];
            end
            lvl  <= lvl_next;
            pend <= pend_next;
            if (led_write) begin
                led <= bus_wdata[LED_W-1:0];
            end
        end
    end

    assign btn_level = lvl;

endmodule
